// File: rtl/player_motion_ctrl_pkg.sv
// Shared screen/box geometry, motion FSM states and the clamped step helper
// used by the player motion controller and the box renderer.
package player_motion_ctrl_pkg;

   localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
   localparam logic [9:0] SCREEN_HEIGHT = 10'd480;
   localparam logic [9:0] BOX_WIDTH     = 10'd30;
   localparam logic [9:0] BOX_HEIGHT    = 10'd30;
   localparam logic [9:0] BOX_Y_START   = 10'd440;
   localparam logic [9:0] MOVE_STEP     = 10'd4;
   localparam logic [9:0] X_START       = 10'd305;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      CALC   = 2'd1,
      COMMIT = 2'd2
   } motion_state_e;

   typedef struct packed {
      logic left;
      logic right;
   } move_dir_t;

   // Comparisons are ordered so the unsigned result never wraps past 0 or x_max.
   function automatic logic [9:0] step_x(input logic [9:0] x,
                                         input move_dir_t  dir,
                                         input logic [9:0] step,
                                         input logic [9:0] x_max);
      logic [9:0] res;
      res = x;
      case ({dir.left, dir.right})
         2'b10:   res = (x < step) ? '0 : x - step;
         2'b01:   res = (x > x_max - step) ? x_max : x + step;
         default: res = x;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/player_motion_ctrl_sync_edge_detect.sv
// Two-flop synchroniser over a bundle of lines; din[0] additionally gets a
// registered one-cycle falling-edge pulse, the other lines pass through as levels.
module sync_edge_detect #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-2:0] sync_o,
   output logic         fall_o
);

   logic [W-1:0] stage0_d, stage0_q;
   logic [W-1:0] stage1_d, stage1_q;
   logic         fall_d, fall_q;

   always_comb begin
      stage0_d = din;
      stage1_d = stage0_q;
      fall_d   = stage1_q[0] & ~stage0_q[0];
   end

   // Lines idle high, so reset loads '1 and no spurious edge follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage0_q <= '1;
         stage1_q <= '1;
         fall_q   <= 1'b0;
      end else begin
         stage0_q <= stage0_d;
         stage1_q <= stage1_d;
         fall_q   <= fall_d;
      end
   end

   assign sync_o = stage1_q[W-1:1];
   assign fall_o = fall_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-synchronous player X controller: samples the move keys once per vsync
// falling edge and steps/clamps player_x so it only changes during vertical sync.
module player_motion_ctrl #(
   parameter logic [9:0] SCREEN_WIDTH = player_motion_ctrl_pkg::SCREEN_WIDTH,
   parameter logic [9:0] BOX_WIDTH    = player_motion_ctrl_pkg::BOX_WIDTH,
   parameter logic [9:0] MOVE_STEP    = player_motion_ctrl_pkg::MOVE_STEP,
   parameter logic [9:0] X_START      = player_motion_ctrl_pkg::X_START
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_left_n,
   input  logic       key_right_n,
   input  logic       freeze,
   input  logic       vsync,
   output logic [9:0] player_x,
   output logic       frame_tick,
   output logic       moved
);

   import player_motion_ctrl_pkg::*;

   localparam logic [9:0] X_MAX = SCREEN_WIDTH - BOX_WIDTH;

   logic [1:0] keys_n_s;
   logic       frame_tick_w;
   logic       left, right;

   // vsync sits on bit 0 to get the edge pulse; keys reuse the same sync stages.
   sync_edge_detect #(
      .W(3)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   ({key_right_n, key_left_n, vsync}),
      .sync_o(keys_n_s),
      .fall_o(frame_tick_w)
   );

   assign left  = ~keys_n_s[0];
   assign right = ~keys_n_s[1];

   motion_state_e state_d, state_q;
   move_dir_t     dir_d, dir_q;
   logic [9:0]    next_x_d, next_x_q;
   logic [9:0]    player_x_d, player_x_q;
   logic          moved_d, moved_q;

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      next_x_d   = next_x_q;
      player_x_d = player_x_q;
      moved_d    = 1'b0;
      case (state_q)
         WAIT: begin
            if (frame_tick_w && !freeze) begin
               dir_d   = '{left: left, right: right};
               state_d = CALC;
            end
         end
         CALC: begin
            next_x_d = step_x(player_x_q, dir_q, MOVE_STEP, X_MAX);
            state_d  = COMMIT;
         end
         COMMIT: begin
            player_x_d = next_x_q;
            moved_d    = (next_x_q != player_x_q);
            state_d    = WAIT;
         end
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT;
         dir_q      <= '0;
         next_x_q   <= X_START;
         player_x_q <= X_START;
         moved_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         next_x_q   <= next_x_d;
         player_x_q <= player_x_d;
         moved_q    <= moved_d;
      end
   end

   assign player_x   = player_x_q;
   assign frame_tick = frame_tick_w;
   assign moved      = moved_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: three instances (start 305, 2, 608) share stimulus
// and are checked every cycle against a frame-level model plus literal expectations.
module tb_player_motion_ctrl;

   localparam int NI   = 3;
   localparam int STEP = 4;
   localparam int XMAX = 640 - 30;
   localparam logic [9:0] XS0 = 10'd305;
   localparam logic [9:0] XS1 = 10'd2;
   localparam logic [9:0] XS2 = 10'd608;

   logic       clk = 1'b0;
   logic       rst, key_left_n, key_right_n, freeze, vsync;
   logic [9:0] px [NI];
   logic       ft [NI];
   logic       mv [NI];

   always #5 clk = ~clk;

   player_motion_ctrl #(.X_START(XS0)) u0 (
      .clk(clk), .rst(rst), .key_left_n(key_left_n), .key_right_n(key_right_n),
      .freeze(freeze), .vsync(vsync), .player_x(px[0]), .frame_tick(ft[0]), .moved(mv[0]));
   player_motion_ctrl #(.X_START(XS1)) u1 (
      .clk(clk), .rst(rst), .key_left_n(key_left_n), .key_right_n(key_right_n),
      .freeze(freeze), .vsync(vsync), .player_x(px[1]), .frame_tick(ft[1]), .moved(mv[1]));
   player_motion_ctrl #(.X_START(XS2)) u2 (
      .clk(clk), .rst(rst), .key_left_n(key_left_n), .key_right_n(key_right_n),
      .freeze(freeze), .vsync(vsync), .player_x(px[2]), .frame_tick(ft[2]), .moved(mv[2]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: histories of sampled inputs, one pending update per instance.
   int  xs [NI] = '{305, 2, 608};
   int  m_pos [NI];
   bit  m_pv [NI];
   int  m_pe [NI];
   int  m_delta [NI];
   bit  m_moved [NI];
   bit  m_tick = 1'b0;
   bit  vs1 = 1'b1, vs2 = 1'b1, kl1 = 1'b1, kl2 = 1'b1, kr1 = 1'b1, kr2 = 1'b1;
   bit  rst_prev = 1'b1;
   bit  armed = 1'b0;
   int  n_edge = 0;

   always @(posedge clk) begin
      bit pl, pr, tprev;
      int np;
      n_edge++;
      pl    = !rst_prev && !kl2;
      pr    = !rst_prev && !kr2;
      tprev = m_tick;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            m_pos[i]   = xs[i];
            m_pv[i]    = 1'b0;
            m_moved[i] = 1'b0;
         end else begin
            m_moved[i] = 1'b0;
            if (m_pv[i]) begin
               if (m_pe[i] == n_edge) begin
                  np = m_pos[i] + m_delta[i];
                  if (np < 0) np = 0;
                  if (np > XMAX) np = XMAX;
                  m_moved[i] = (np != m_pos[i]);
                  m_pos[i]   = np;
                  m_pv[i]    = 1'b0;
               end
            end else if (tprev && !freeze) begin
               m_pv[i]    = 1'b1;
               m_pe[i]    = n_edge + 2;
               m_delta[i] = (pl && !pr) ? -STEP : ((pr && !pl) ? STEP : 0);
            end
         end
      end
      m_tick   = rst ? 1'b0 : (vs2 && !vs1);
      vs2      = vs1;
      vs1      = rst ? 1'b1 : vsync;
      kl2      = kl1;
      kl1      = rst ? 1'b1 : key_left_n;
      kr2      = kr1;
      kr1      = rst ? 1'b1 : key_right_n;
      rst_prev = rst;
      if (rst) armed = 1'b1;
   end

   int cnt_mv [NI] = '{0, 0, 0};
   int cnt_ft = 0;

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("player_x[%0d]", i), int'(px[i]), m_pos[i]);
            check($sformatf("frame_tick[%0d]", i), int'(ft[i]), int'(m_tick));
            check($sformatf("moved[%0d]", i), int'(mv[i]), int'(m_moved[i]));
            cnt_mv[i] += int'(mv[i]);
         end
         cnt_ft += int'(ft[0]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic frame();
      vsync = 1'b0;
      cyc(6);
      vsync = 1'b1;
      cyc(6);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NI; i++) cnt_mv[i] = 0;
      cnt_ft = 0;
   endtask

   initial begin
      rst = 1'b1; key_left_n = 1'b1; key_right_n = 1'b1; freeze = 1'b0; vsync = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         key_left_n  = ~key_left_n;
         key_right_n = (i == 1);
         vsync       = ~vsync;
      end
      rst = 1'b0; key_left_n = 1'b1; key_right_n = 1'b1; vsync = 1'b1;
      cyc(4);
      check("reset_x0", int'(px[0]), 305);
      check("reset_x1", int'(px[1]), 2);
      check("reset_x2", int'(px[2]), 608);
      check("reset_moved", int'(mv[0]), 0);

      key_right_n = 1'b0;
      cyc(3);
      clear_counts();
      repeat (3) frame();
      key_right_n = 1'b1;
      cyc(3);
      check("right_x0", int'(px[0]), 317);
      check("right_x1", int'(px[1]), 14);
      check("right_clamp_x2", int'(px[2]), 610);
      check("right_moved_cnt0", cnt_mv[0], 3);
      check("right_clamp_moved_cnt2", cnt_mv[2], 1);
      check("right_tick_cnt", cnt_ft, 3);
      reset_pulse();

      key_left_n = 1'b0;
      cyc(3);
      clear_counts();
      repeat (2) frame();
      key_left_n = 1'b1;
      cyc(3);
      check("left_clamp_x1", int'(px[1]), 0);
      check("left_clamp_moved_cnt1", cnt_mv[1], 1);
      check("left_x0", int'(px[0]), 297);
      check("left_x2", int'(px[2]), 600);
      reset_pulse();

      key_left_n = 1'b0; key_right_n = 1'b0;
      cyc(3);
      clear_counts();
      repeat (4) frame();
      key_left_n = 1'b1; key_right_n = 1'b1;
      cyc(3);
      check("both_x0", int'(px[0]), 305);
      check("both_tick_cnt", cnt_ft, 4);
      check("both_moved_cnt0", cnt_mv[0], 0);

      freeze = 1'b1; key_right_n = 1'b0;
      cyc(3);
      clear_counts();
      repeat (4) frame();
      key_right_n = 1'b1;
      cyc(3);
      freeze = 1'b0;
      check("freeze_x0", int'(px[0]), 305);
      check("freeze_tick_cnt", cnt_ft, 4);
      check("freeze_moved_cnt0", cnt_mv[0], 0);

      key_right_n = 1'b0;
      cyc(3);
      clear_counts();
      vsync = 1'b0;
      cyc(2);
      check("midupd_tick", int'(ft[0]), 1);
      cyc(1);
      rst = 1'b1; vsync = 1'b1; key_right_n = 1'b1;
      cyc(1);
      check("midupd_x0", int'(px[0]), 305);
      check("midupd_moved", int'(mv[0]), 0);
      rst = 1'b0;
      cyc(6);
      check("midupd_x0_after", int'(px[0]), 305);
      check("midupd_moved_cnt0", cnt_mv[0], 0);
      check("midupd_tick_cnt", cnt_ft, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule
